uart_cmd_arbiter: RTL

Round-robin scheduler that shares one UART byte transmitter among NUM_REQ command sources. Each source offers a CMD_WIDTH-bit command with a valid/ready handshake. The block grants one source, serializes its command MSB-byte-first into the transmitter's byte handshake, then enforces an idle gap before the next grant. It sits between the command producers and the UART TX datapath.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_rr_arbiter.sv | 24 ++
 rtl/uart_cmd_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and byte/gap constants for the UART command arbiter
package uart_pkg;
   typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;
   localparam int BYTE_W = 8;
   localparam int GAP_DEFAULT = 50_000_000 / 115_200;
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin search (req_vld, ptr in; one-hot gnt, idx, any out)
module uart_rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_vld,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx,
   output logic               any
);
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_vld[(int'(ptr) + k) % NUM_REQ]) begin
            idx = IW'((int'(ptr) + k) % NUM_REQ);
            any = 1'b1;
         end
      end
      gnt[idx] = any;
   end
endmodule

// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter: round-robin grant of req_vld/req_cmd sources, MSB-first byte stream on byte_data/byte_vld/byte_rdy, then idle gap; reports grant_id and busy
module uart_cmd_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int CMD_WIDTH = 16,
   parameter int GAP_CYCLES = GAP_DEFAULT,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_vld,
   input  logic [NUM_REQ*CMD_WIDTH-1:0]   req_cmd,
   output logic [NUM_REQ-1:0]             req_rdy,
   output logic [BYTE_W-1:0]              byte_data,
   output logic                           byte_vld,
   input  logic                           byte_rdy,
   output logic [IW-1:0]                  grant_id,
   output logic                           busy
);
   localparam int NB = CMD_WIDTH / BYTE_W;
   localparam int BW = $clog2(NB + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   state_e               state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d, gid_q, gid_d, widx;
   logic [CMD_WIDTH-1:0] sh_q, sh_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic [GW-1:0]        gcnt_q, gcnt_d;
   logic [NUM_REQ-1:0]   gnt;
   logic                 any;
   uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_vld(req_vld),
      .ptr    (ptr_q),
      .gnt    (gnt),
      .idx    (widx),
      .any    (any)
   );
   assign req_rdy   = (state_q == IDLE) ? gnt : '0;
   assign byte_vld  = state_q == SEND;
   assign byte_data = byte_vld ? sh_q[CMD_WIDTH-1 -: BYTE_W] : '0;
   assign grant_id  = gid_q;
   assign busy      = state_q != IDLE;
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      sh_d    = sh_q;
      bcnt_d  = bcnt_q;
      gcnt_d  = gcnt_q;
      case (state_q)
         IDLE: if (any) begin
            sh_d    = req_cmd[widx*CMD_WIDTH +: CMD_WIDTH];
            gid_d   = widx;
            ptr_d   = (widx == IW'(NUM_REQ - 1)) ? '0 : widx + 1'b1;
            bcnt_d  = '0;
            state_d = SEND;
         end
         SEND: if (byte_rdy) begin
            sh_d   = sh_q << BYTE_W;
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == BW'(NB - 1)) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
         end
         GAP: begin
            gcnt_d  = (gcnt_q == GW'(GAP_CYCLES - 1)) ? '0 : gcnt_q + 1'b1;
            state_d = (gcnt_q == GW'(GAP_CYCLES - 1)) ? IDLE : GAP;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         sh_q    <= '0;
         bcnt_q  <= '0;
         gcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         sh_q    <= sh_d;
         bcnt_q  <= bcnt_d;
         gcnt_q  <= gcnt_d;
      end
   end
endmodule
